// File: rtl/alu_arbiter.sv
// Round-robin valid/ready arbiter sharing one alu_32 between two requesters.
// Define ALU_ARB_FIXED_PRIO_EN to make req0 always win ties.
module alu_arbiter #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [31:0]      req0_inst,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [31:0]      req1_inst,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_z,
    output logic             rsp_v,
    output logic             rsp_n,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [31:0]      alu_inst,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_z,
    input  logic             alu_v,
    input  logic             alu_n,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             grant_valid;
    logic             grant_id;
    logic             accept;
    logic             sel_mop;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [31:0]      sel_inst;

    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant_id = 1'b0;
`else
            grant_id = ~last_grant;
`endif
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign accept     = (state == IDLE) && grant_valid;
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;
    assign busy       = (state != IDLE);

    assign sel_a    = grant_id ? req1_a    : req0_a;
    assign sel_b    = grant_id ? req1_b    : req0_b;
    assign sel_inst = grant_id ? req1_inst : req0_inst;
    // M-extension decode also catches DIV/REM, which share the multi-cycle budget
    assign sel_mop  = (sel_inst[6:0] == 7'b0110011) && (sel_inst[31:25] == 7'b0000001);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    if (cnt == '0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_inst   <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_out    <= '0;
            rsp_z      <= 1'b0;
            rsp_v      <= 1'b0;
            rsp_n      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a      <= sel_a;
                        alu_b      <= sel_b;
                        alu_inst   <= sel_inst;
                        rsp_id     <= grant_id;
                        last_grant <= grant_id;
                        cnt        <= sel_mop ? MUL_LOAD : '0;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        rsp_out   <= alu_out;
                        rsp_z     <= alu_z;
                        rsp_v     <= alu_v;
                        rsp_n     <= alu_n;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
